hamming_uart_tx_core: RTL and testbench

//  - Takes a 4-bit nibble on a rising edge of start and Hamming(7,4)-encodes it.
//  - Sends the codeword as one 8N1 UART frame on tx.
//  - Carries a free-running 3-bit debug counter.
//  - Core datapath behind the chip-level pin wrapper: ui_in[3:0] -> data_in, ui_in[4] -> start,
//    uo_out[0] <- tx, uo_out[3:1] <- count.

---
 rtl/hamming_uart_tx_core.sv | 121 ++++++++++++
 tb/tb_hamming_uart_tx_core.sv | 123 ++++++++++++
 2 files changed

// File: rtl/hamming_uart_tx_core.sv
// hamming_uart_tx_core: Hamming(7,4) nibble encoder feeding an 8N1 UART transmitter plus a debug counter.
// Define HAMMING_SECDED_EN to send overall even parity in frame bit 7 (extended SECDED word).
module hamming_uart_tx_core #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_data_in,
    input  logic       i_start,
    output logic       o_tx,
    output logic       o_tx_busy,
    output logic [6:0] o_code_out,
    output logic       o_code_valid,
    output logic [2:0] o_count
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_start_d;
    logic [6:0]    r_code;
    logic          r_valid;
    logic [2:0]    r_count;
    logic [BW-1:0] r_baud, w_baud_nxt;
    logic [2:0]    r_idx, w_idx_nxt;
    logic [7:0]    r_byte, w_byte_nxt;
    logic          r_tx, w_tx_nxt;
    logic          r_busy, w_busy_nxt;
    logic          w_edge, w_bit_end, w_b7;
    logic [6:0]    w_code;

    assign w_edge    = i_start & ~r_start_d;
    assign w_bit_end = (r_baud == LAST);
    assign w_code    = {i_data_in[3], i_data_in[2], i_data_in[1],
                        i_data_in[1] ^ i_data_in[2] ^ i_data_in[3], i_data_in[0],
                        i_data_in[0] ^ i_data_in[2] ^ i_data_in[3],
                        i_data_in[0] ^ i_data_in[1] ^ i_data_in[3]};
`ifdef HAMMING_SECDED_EN
    assign w_b7 = ^r_code;
`else
    assign w_b7 = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_d <= 1'b0;
            r_code    <= '0;
            r_valid   <= 1'b0;
            r_count   <= '0;
        end else begin
            r_start_d <= i_start;
            r_valid   <= w_edge;
            r_count   <= r_count + 3'd1;
            if (w_edge) r_code <= w_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_idx   <= '0;
            r_byte  <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_idx   <= w_idx_nxt;
            r_byte  <= w_byte_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Outputs are computed one cycle ahead so tx/busy come straight from flops.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = w_bit_end ? '0 : r_baud + 1'b1;
        w_idx_nxt   = r_idx;
        w_byte_nxt  = r_byte;
        w_tx_nxt    = r_tx;
        w_busy_nxt  = r_busy;
        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
                if (r_valid) begin
                    w_state_nxt = S_START;
                    w_byte_nxt  = {w_b7, r_code};
                    w_tx_nxt    = 1'b0;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_START: if (w_bit_end) begin
                w_state_nxt = S_DATA;
                w_idx_nxt   = '0;
                w_tx_nxt    = r_byte[0];
            end
            S_DATA: if (w_bit_end) begin
                w_idx_nxt   = r_idx + 3'd1;
                w_state_nxt = (r_idx == 3'd7) ? S_STOP : S_DATA;
                w_tx_nxt    = (r_idx == 3'd7) ? 1'b1 : r_byte[w_idx_nxt];
            end
            S_STOP: if (w_bit_end) begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_tx         = r_tx;
    assign o_tx_busy    = r_busy;
    assign o_code_out   = r_code;
    assign o_code_valid = r_valid;
    assign o_count      = r_count;
endmodule

// File: tb/tb_hamming_uart_tx_core.sv
// tb_hamming_uart_tx_core: directed checks of encoding, frame timing, busy overlap, held start and reset.
module tb_hamming_uart_tx_core;
    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] data_in = 4'h0;
    logic       start = 1'b0;
    logic       tx, tx_busy, code_valid;
    logic [6:0] code_out;
    logic [2:0] count;
    int tests = 0;
    int fails = 0;

    hamming_uart_tx_core #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .i_data_in(data_in), .i_start(start),
        .o_tx(tx), .o_tx_busy(tx_busy), .o_code_out(code_out),
        .o_code_valid(code_valid), .o_count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start with nibble d, then follow the whole frame cycle by cycle.
    // inj_k >= 0 raises a second start edge (nibble inj_d) that many cycles into the frame.
    // rel_k >= 0 keeps start high until that cycle.
    task automatic send(input logic [3:0] d, input logic [6:0] code, input logic [7:0] fb,
                        input int inj_k, input logic [3:0] inj_d, input logic [6:0] inj_code,
                        input int rel_k);
        logic [6:0] ec;
        logic       etx;
        @(negedge clk);
        data_in = d;
        start   = 1'b1;
        @(negedge clk);
        check("code", 8'(code_out), 8'(code));
        check("valid_hi", 8'(code_valid), 8'h1);
        check("tx_pre", 8'(tx), 8'h1);
        check("busy_pre", 8'(tx_busy), 8'h0);
        data_in = ~d;
        if (rel_k < 0) start = 1'b0;
        for (int k = 0; k <= 80; k++) begin
            @(negedge clk);
            ec  = (inj_k >= 0 && k > inj_k) ? inj_code : code;
            etx = (k / CPB == 0) ? 1'b0 : (k / CPB >= 9) ? 1'b1 : fb[k / CPB - 1];
            check("tx_bit", 8'(tx), 8'(etx));
            check("busy", 8'(tx_busy), (k < 80) ? 8'h1 : 8'h0);
            check("code_hold", 8'(code_out), 8'(ec));
            check("valid", 8'(code_valid), (inj_k >= 0 && k == inj_k + 1) ? 8'h1 : 8'h0);
            if (k == inj_k) begin
                data_in = inj_d;
                start   = 1'b1;
            end
            if (k == inj_k + 1 || k == rel_k) start = 1'b0;
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("idle_tx", 8'(tx), 8'h1);
            check("idle_busy", 8'(tx_busy), 8'h0);
        end
    endtask

    initial begin
        logic [2:0] c0;
        repeat (3) @(negedge clk);
        check("rst_tx", 8'(tx), 8'h1);
        check("rst_busy", 8'(tx_busy), 8'h0);
        check("rst_code", 8'(code_out), 8'h0);
        check("rst_valid", 8'(code_valid), 8'h0);
        check("rst_count", 8'(count), 8'h0);
        rst_n = 1'b1;
        c0 = count;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check("count", 8'(count), 8'(3'(c0 + 3'(i))));
        end
`ifdef HAMMING_SECDED_EN
        send(4'b1011, 7'h55, 8'h55, -1, 4'h0, 7'h00, -1);
        send(4'h1,    7'h07, 8'h87, -1, 4'h0, 7'h00, -1);
        send(4'hF,    7'h7F, 8'hFF, -1, 4'h0, 7'h00, -1);
`else
        send(4'b1011, 7'h55, 8'h55, -1, 4'h0, 7'h00, -1);
        send(4'h1,    7'h07, 8'h07, -1, 4'h0, 7'h00, -1);
        send(4'hF,    7'h7F, 8'h7F, -1, 4'h0, 7'h00, -1);
`endif
        send(4'h0, 7'h00, 8'h00, -1, 4'h0, 7'h00, -1);
        send(4'h6, 7'h33, 8'h33, -1, 4'h0, 7'h00, -1);
        send(4'b1011, 7'h55, 8'h55, 2, 4'hF, 7'h7F, -1);
        send(4'h1, 7'h07, {7'h00, 1'b0} | 8'h07
`ifdef HAMMING_SECDED_EN
             | 8'h80
`endif
             , -1, 4'h0, 7'h00, 48);
        @(negedge clk);
        data_in = 4'hF;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_busy", 8'(tx_busy), 8'h1);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_tx", 8'(tx), 8'h1);
        check("mrst_busy", 8'(tx_busy), 8'h0);
        check("mrst_count", 8'(count), 8'h0);
        check("mrst_code", 8'(code_out), 8'h0);
        check("mrst_valid", 8'(code_valid), 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("post_tx", 8'(tx), 8'h1);
        check("post_busy", 8'(tx_busy), 8'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
